// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared CPU constants: exception codes, NOP word, IF/ID queue
//             depth (DEPTH=2 when IFQ_DEPTH2_EN is defined, otherwise 1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

`ifdef IFQ_DEPTH2_EN
    localparam int c_IFQ_DEPTH = 2;
`else
    localparam int c_IFQ_DEPTH = 1;
`endif

    // One pointer bit covers both builds; in the DEPTH=1 build it stays at 0.
    localparam int c_PTR_W = 1;

    localparam logic [4:0]  c_EXC_ADEL = 5'd4;
    localparam logic [4:0]  c_EXC_RI   = 5'd10;
    localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;

    typedef logic [1:0] ifq_count_t;

    function automatic logic [c_PTR_W-1:0] ifq_ptr_next(input logic [c_PTR_W-1:0] ptr);
        if (ptr == c_PTR_W'(c_IFQ_DEPTH - 1))
            return '0;
        else
            return ptr + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifq_entry_ram.sv
// ============================================================================
//  Module   : ifq_entry_ram
//  Brief    : DEPTH x WIDTH entry storage, synchronous write, async read.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_entry_ram #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 71,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are never reset: occupancy in the parent masks stale data.
    generate
        if (DEPTH == 1) begin : g_single
            logic [WIDTH-1:0] r_mem;
            logic             w_unused_addr;

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem <= i_wdata;
                end
            end

            assign o_rdata       = r_mem;
            assign w_unused_addr = ^{i_waddr, i_raddr};
        end else begin : g_array
            logic [WIDTH-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
            end

            assign o_rdata = r_mem[i_raddr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
//  Module   : if_id_queue
//  Brief    : IF->ID decoupling FIFO. IFQ_DEPTH2_EN selects a 2-entry skid
//             queue with registered in_ready; default is a 1-entry register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              in_exp,
    input  logic [4:0]        in_exccode,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              out_exp,
    output logic [4:0]        out_exccode,
    output logic              out_bd,
    input  logic              flush,
    output logic [1:0]        count
);

    localparam int c_ENTRY_W = 2 * DATA_W + 7;

    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    ifq_count_t           r_count;

    logic                 w_push;
    logic                 w_pop;
    logic [DATA_W-1:0]    w_instr_st;
    logic [c_ENTRY_W-1:0] w_wdata;
    logic [c_ENTRY_W-1:0] w_rdata;
    logic [c_ENTRY_W-1:0] w_head;

`ifdef IFQ_DEPTH2_EN
    // Ready depends only on registered occupancy; the skid entry absorbs
    // the word already in flight when ID stalls.
    assign in_ready = (r_count < 2'(c_IFQ_DEPTH));
`else
    assign in_ready = (r_count == 2'd0) | out_ready;
`endif

    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // A faulting fetch is stored as a NOP but keeps its pc and cause.
    assign w_instr_st = in_exp ? DATA_W'(c_NOP_WORD) : in_instr;
    assign w_wdata    = {in_pc, w_instr_st, in_exp, in_exccode, in_bd};

    ifq_entry_ram #(
        .DEPTH (c_IFQ_DEPTH),
        .WIDTH (c_ENTRY_W),
        .PTR_W (c_PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push & ~flush),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 2'd0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ifq_ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ifq_ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = out_valid ? w_rdata : '0;
    assign {out_pc, out_instr, out_exp, out_exccode, out_bd} = w_head;
    assign count  = r_count;

endmodule

`default_nettype wire

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning PC and instruction word width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1, forming the fetch-side handshake; a push occurs when both are high at a clk edge.
REQ-005 SHALL have ports in_pc input 32, in_instr input 32, in_exp input 1, in_exccode input 5 and in_bd input 1, carrying the IF-stage PC, fetched word, fetch-exception flag, code and delay-slot bit.
REQ-006 SHALL have ports out_valid output 1 and out_ready input 1, where out_ready is ID's inverted hold, forming the decode-side handshake; a pop occurs when both are high at a clk edge.
REQ-007 SHALL have ports out_pc output 32, out_instr output 32, out_exp output 1, out_exccode output 5 and out_bd output 1, carrying the head entry.
REQ-008 SHALL have port flush input 1, asserted on exc or eret, which discards all entries.
REQ-009 SHALL have port count output 2, giving current occupancy.

Function
REQ-010 SHALL be a FIFO of DEPTH entries (2 or 1, per Configuration) with circular read and write pointers wrapping at DEPTH.
REQ-011 SHALL drive in_ready = (count < DEPTH) when DEPTH=2, which leaves no combinational path from out_ready.
REQ-012 SHALL drive in_ready = (count==0) | out_ready when DEPTH=1.
REQ-013 SHALL drive out_valid = (count != 0) and present the head entry combinationally, with zero-cycle read latency.
REQ-014 SHALL, when empty, drive out_pc=0, out_instr=0 (nop), out_exp=0, out_exccode=0 and out_bd=0.
REQ-015 SHALL store in_instr as 0 when in_exp=1, so a faulting fetch decodes as a nop while still carrying exp/exccode/pc.
REQ-016 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers; this is legal when full with DEPTH=1 only through REQ-012.
REQ-017 SHALL ignore a push when in_ready=0 and ignore a pop when out_valid=0, with pointers and count unchanged.
REQ-018 SHALL, when flush=1 at a clk edge, zero count and both pointers, drop any concurrent push and pop, and produce out_valid=0 in the next cycle.
REQ-019 SHALL give flush priority over every other event.
REQ-020 SHALL have push-to-out_valid latency of 1 cycle when empty.
REQ-021 SHALL guarantee count never exceeds DEPTH and never underflows.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear count and both pointers, with all outputs at REQ-014 values and in_ready=1.
REQ-023 SHALL treat assertion mid-transfer as an abort, losing all stored entries.
REQ-024 SHALL leave storage RAM contents uncleared on reset, because they are masked by count.

Configuration
REQ-025 SHALL, with macro IFQ_DEPTH2_EN defined, set DEPTH=2, using the skid entry so full throughput holds with registered in_ready.
REQ-026 SHALL, without IFQ_DEPTH2_EN, set DEPTH=1, behaving as a stallable IF/ID register with the REQ-012 ready.
REQ-027 SHALL keep count 2 bits wide in both builds, never exceeding 1 in the DEPTH=1 build.

Structure
REQ-028 SHALL take the ExcCode constants (EXC_ADEL=5'd4, EXC_RI=5'd10), the NOP word and the DEPTH macro from shared package cpu_pkg.
REQ-029 SHALL contain one sub-module, ifq_entry_ram, holding DEPTH x 71-bit storage {pc, instr, exp, exccode, bd}, written at wptr and read asynchronously at rptr.

Verification
REQ-030 SHALL cover: reset=0 then release -> count=0, in_ready=1, out_valid=0, out_instr=0.
REQ-031 SHALL cover: push pc=0x3000 instr=0x24080001 with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, count=1.
REQ-032 SHALL cover (DEPTH=2): push 0x3000 and 0x3004 with out_ready=0 -> count=2 and in_ready=0; then out_ready=1 -> pops in order 0x3000, 0x3004.
REQ-033 SHALL cover: push pc=0x3002, in_exp=1, exccode=4, instr=0xFFFFFFFF -> out_instr=0, out_exp=1, out_exccode=4.
REQ-034 SHALL cover: queue full while flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, pushed entry absent.
REQ-035 SHALL cover: continuous in_valid/out_ready for 10 cycles on pc 0x3000..0x3024 -> one pop per cycle after the first, order and bd bits preserved.
